// File: rtl/platform_landing_scanner.sv
// Sequential per-frame landing detector: one platform slot per clock, first-surface-wins hit selection.
// Latency N_PLAT+2 cycles tick-to-done; ticks while a scan is running are dropped and flagged on o_overrun.
module platform_landing_scanner #(
    parameter int N_PLAT   = 93,
    parameter int X_W      = 11,
    parameter int Y_W      = 10,
    parameter int DOODLE_W = 80,
    parameter int DOODLE_H = 80,
    parameter int PLAT_W   = 100,
    parameter int FLOOR_Y  = 690,
    localparam int IDX_W   = (N_PLAT > 1) ? $clog2(N_PLAT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_frame_tick,
    input  logic [X_W-1:0]        i_doodle_x,
    input  logic [Y_W-1:0]        i_doodle_y,
    input  logic [N_PLAT*X_W-1:0] i_plat_x,
    input  logic [N_PLAT*Y_W-1:0] i_plat_y,
    input  logic [N_PLAT-1:0]     i_plat_active,
    input  logic [N_PLAT*2-1:0]   i_plat_kind,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_hit,
    output logic [IDX_W-1:0]      o_hit_idx,
    output logic [1:0]            o_hit_kind,
    output logic [Y_W-1:0]        o_ground_y,
    output logic [X_W-1:0]        o_ground_x,
    output logic                  o_break_req,
    output logic                  o_overrun
);

    // Two guard bits so bounds such as plat_x-(DOODLE_W-1) can go negative without wrapping.
    localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam logic signed [CW-1:0] C_DH    = CW'(DOODLE_H);
    localparam logic signed [CW-1:0] C_DWM1  = CW'(DOODLE_W - 1);
    localparam logic signed [CW-1:0] C_PWM1  = CW'(PLAT_W - 1);
    localparam logic [IDX_W-1:0]     C_LAST  = IDX_W'(N_PLAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

    state_t r_state, w_next;
    logic   w_start, w_scan, w_commit;

    logic [IDX_W-1:0] r_idx;
    logic [X_W-1:0]   r_cur_x;
    logic [Y_W-1:0]   r_cur_y, r_prev_y;
    logic             r_falling;

    logic             r_cand_vld;
    logic [IDX_W-1:0] r_cand_idx;
    logic [1:0]       r_cand_kind;
    logic [X_W-1:0]   r_cand_x;
    logic [Y_W-1:0]   r_cand_y;

    logic [X_W-1:0]   w_slot_x;
    logic [Y_W-1:0]   w_slot_y;
    logic [1:0]       w_slot_kind;
    logic             w_slot_act;
    logic signed [CW-1:0] w_px, w_py, w_cx, w_cy, w_pry;
    logic             w_in_y, w_in_x, w_hit, w_better;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_frame_tick) w_next = S_SCAN;
            S_SCAN:   if (r_idx == C_LAST) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start  = (r_state == S_IDLE) && i_frame_tick;
        w_scan   = (r_state == S_SCAN);
        w_commit = (r_state == S_COMMIT);
        // Busy stays high through the done cycle even though the FSM is already back in IDLE.
        o_busy   = (r_state != S_IDLE) || o_done;
    end

    assign w_slot_x    = i_plat_x[int'(r_idx)*X_W +: X_W];
    assign w_slot_y    = i_plat_y[int'(r_idx)*Y_W +: Y_W];
    assign w_slot_kind = i_plat_kind[int'(r_idx)*2 +: 2];
    assign w_slot_act  = i_plat_active[r_idx];

    assign w_px  = $signed(CW'(w_slot_x));
    assign w_py  = $signed(CW'(w_slot_y));
    assign w_cx  = $signed(CW'(r_cur_x));
    assign w_cy  = $signed(CW'(r_cur_y));
    assign w_pry = $signed(CW'(r_prev_y));

    // Foot crossed the platform top since the previous frame, and sprite overlaps horizontally.
    assign w_in_y   = (w_py >= w_pry + C_DH) && (w_py <= w_cy + C_DH);
    assign w_in_x   = (w_cx >= w_px - C_DWM1) && (w_cx <= w_px + C_PWM1);
    assign w_hit    = w_slot_act && r_falling && w_in_y && w_in_x;
    assign w_better = !r_cand_vld || (w_slot_y < r_cand_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_cur_x     <= '0;
            r_cur_y     <= i_doodle_y;
            r_prev_y    <= i_doodle_y;
            r_falling   <= 1'b0;
            r_cand_vld  <= 1'b0;
            r_cand_idx  <= '0;
            r_cand_kind <= '0;
            r_cand_x    <= '0;
            r_cand_y    <= '0;
            o_done      <= 1'b0;
            o_hit       <= 1'b0;
            o_hit_idx   <= '0;
            o_hit_kind  <= '0;
            o_ground_y  <= Y_W'(FLOOR_Y);
            o_ground_x  <= '0;
            o_break_req <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_overrun   <= i_frame_tick && (r_state != S_IDLE);
            o_done      <= w_commit;
            o_break_req <= w_commit && r_cand_vld && (r_cand_kind == 2'd2);
            if (w_start) begin
                r_cur_x    <= i_doodle_x;
                r_cur_y    <= i_doodle_y;
                r_prev_y   <= r_cur_y;
                r_falling  <= i_doodle_y > r_cur_y;
                r_cand_vld <= 1'b0;
                r_idx      <= '0;
            end
            if (w_scan) begin
                r_idx <= r_idx + 1'b1;
                // Strict compare keeps the lower index on equal heights.
                if (w_hit && w_better) begin
                    r_cand_vld  <= 1'b1;
                    r_cand_idx  <= r_idx;
                    r_cand_kind <= w_slot_kind;
                    r_cand_x    <= w_slot_x;
                    r_cand_y    <= w_slot_y;
                end
            end
            if (w_commit) begin
                r_idx <= '0;
                o_hit <= r_cand_vld;
                if (r_cand_vld) begin
                    o_hit_idx  <= r_cand_idx;
                    o_hit_kind <= r_cand_kind;
                    o_ground_x <= r_cand_x;
                    o_ground_y <= r_cand_y;
                end
            end
        end
    end

endmodule

// File: doc/platform_landing_scanner.md
# platform_landing_scanner

Per-frame landing detector for the Doodle Jump datapath. It sits between the platform generator and the physics/jump controller. On each frame tick it scans a parametrised number of platforms sequentially, one per clock. It reports the platform the doodle landed on this frame, together with that platform's kind and index, and keeps a registered "ground" coordinate for the physics block. Unlike the earlier combinational observer, this block:
- detects a true top-surface crossing between consecutive frames,
- resolves multiple hits deterministically,
- runs under a start/done handshake.

## Interface
Parameters:
- N_PLAT, 93: number of platform slots scanned per frame (≥1).
- X_W, 11: width of x coordinates (unsigned).
- Y_W, 10: width of y coordinates (unsigned, y grows downward).
- DOODLE_W, 80: doodle sprite width in pixels.
- DOODLE_H, 80: doodle sprite height in pixels.
- PLAT_W, 100: platform width in pixels.
- FLOOR_Y, 690: ground y value after reset.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- frame_tick, in, 1: one-cycle pulse that starts a scan.
- doodle_x, in, X_W: doodle left edge; sampled on an accepted frame_tick.
- doodle_y, in, Y_W: doodle top edge; sampled on an accepted frame_tick.
- plat_x, in, N_PLAT×X_W: platform left edges.
- plat_y, in, N_PLAT×Y_W: platform top edges.
- plat_active, in, N_PLAT: slot valid bits.
- plat_kind, in, N_PLAT×2: 0 normal, 1 spring, 2 breakable, 3 reserved (treated as normal).
- busy, out, 1: scan in progress.
- done, out, 1: one-cycle pulse when results are committed.
- hit, out, 1: a landing occurred in the last completed scan.
- hit_idx, out, $clog2(N_PLAT): slot index of the landing platform.
- hit_kind, out, 2: kind of the landing platform.
- ground_y, out, Y_W: y of the last landed platform.
- ground_x, out, X_W: x of the last landed platform.
- break_req, out, 1: one-cycle pulse alongside done when hit_kind==2.
- overrun, out, 1: one-cycle pulse when a frame_tick arrives while busy.

## Operation
- FSM states:
  - IDLE: waiting for frame_tick.
  - SCAN: evaluating one slot per cycle; counter i runs 0..N_PLAT-1.
  - COMMIT: one cycle.
- IDLE→SCAN on frame_tick:
  - Latch doodle_x/doodle_y into cur_x/cur_y.
  - Move the previous cur_y into prev_y.
  - Set falling = (cur_y > prev_y) as an unsigned compare.
  - Clear the candidate register.
- prev_y reset value = doodle_y sampled during reset, so the first scan after reset has falling=0.
- Slot i is a hit when all of the following hold:
  - plat_active[i];
  - falling;
  - prev_y + DOODLE_H ≤ plat_y[i] ≤ cur_y + DOODLE_H (the foot crossed the platform top this frame, inclusive at both ends);
  - plat_x[i] − (DOODLE_W−1) ≤ cur_x ≤ plat_x[i] + PLAT_W − 1.
- Width rules: all sums and differences are computed sign-extended to max(X_W,Y_W)+2 bits. No wrap is allowed. plat_x[i] < DOODLE_W−1 yields a negative lower bound, which is legal.
- Candidate selection: keep the hit with the smallest plat_y, i.e. the first surface met. On equal plat_y the lower index wins, so a later slot replaces the candidate only if its plat_y is strictly smaller.
- SCAN→COMMIT after slot N_PLAT-1 is evaluated.
- COMMIT→IDLE unconditionally. In COMMIT:
  - Always: assert done for one cycle.
  - If a candidate exists: hit=1; hit_idx, hit_kind, ground_x, ground_y take the candidate's values; break_req=1 if kind==2.
  - If no candidate: hit=0, and ground_x/ground_y/hit_idx/hit_kind hold their previous values.
- plat_* inputs must be stable from the accepted tick through COMMIT; the block does not latch them.
- frame_tick while busy: ignored (no restart), overrun pulses the next cycle.
- Reset values: busy=0, done=0, hit=0, hit_idx=0, hit_kind=0, ground_y=FLOOR_Y, ground_x=0, break_req=0, overrun=0, FSM=IDLE, i=0.
- Reset mid-scan aborts the scan: nothing is committed and all outputs take their reset values on the next edge.

## Timing
- frame_tick sampled high at edge T (in IDLE).
- Edges T+1..T+N_PLAT evaluate slots 0..N_PLAT-1.
- Edge T+N_PLAT+1 registers the results.
- done, break_req, and updated hit/ground are visible in the cycle after edge T+N_PLAT+1. Latency is N_PLAT+2 cycles from the tick to done being visible.
- busy=1 from the cycle after edge T through the done cycle inclusive.
- A frame_tick in the done cycle is accepted, giving back-to-back scans with no gap.
- Throughput: one scan per N_PLAT+2 cycles at most.

## Test plan
- Test-bench parameters: N_PLAT=4, DOODLE_W=DOODLE_H=80, PLAT_W=100.
- Reset: assert rst for 2 cycles → ground_y=690, hit=0, busy=0; the first tick gives done after 6 cycles with hit=0 (falling=0).
- Simple landing: prev doodle_y=500 then 530, cur_x=200, slot 2 at (150,600) active kind 0 → hit=1, hit_idx=2, ground=(150,600), break_req=0.
- Rising or no crossing, each as its own scan against a platform at y=600: (a) doodle_y 530→500 (rising) gives hit=0 and ground unchanged; (b) prev foot 605, cur foot 640 (prev foot already below the top) gives hit=0.
- Priority: slots 0 and 3 both crossed at y=610 and slot 1 at y=605 → hit_idx=1. Then with slot 1 deactivated, slots 0 and 3 both at y=610 → hit_idx=0.
- Horizontal edges, each as its own scan against a platform at x=150 with a valid crossing: cur_x=71 gives hit; cur_x=70 gives no hit; cur_x=249 gives hit; cur_x=250 gives no hit.
- Kind, overrun, and reset abort: a breakable hit gives break_req pulsing with done. A tick at the 3rd busy cycle gives an overrun pulse and done timing unchanged. rst during SCAN gives no done and outputs at reset values.
